frame_ram_arbiter: RTL and testbench

- Shares the single-port 64K x 8 image RAM between the VGA scan-out read stream and a pixel write requester (camera/processing path).
- VGA reads have fixed priority. Writes are queued in an internal FIFO and drained on cycles the VGA does not read (blanking and out-of-image regions).
- Sits between the VGA timing block and the image RAM instance. Same clock as the VGA pixel clock.

---
 rtl/frame_ram_arbiter.sv | 184 ++++++++++++++++++
 tb/tb_frame_ram_arbiter.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_ram_arbiter.sv
// Arbitrates the single-port frame RAM between VGA scan-out reads (fixed priority)
// and a FIFO-buffered pixel write path. Optional starvation guard: ARB_STARVE_GUARD_EN.
module frame_ram_arbiter #(
    parameter int unsigned ADDR_W     = 16,
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned STALL_MAX  = 64
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        vga_rd_en,
    input  logic [ADDR_W-1:0]           vga_addr,
    output logic [DATA_W-1:0]           vga_data,
    output logic                        vga_data_valid,
    output logic                        vga_miss,
    input  logic                        wr_valid,
    input  logic [ADDR_W-1:0]           wr_addr,
    input  logic [DATA_W-1:0]           wr_data,
    output logic                        wr_ready,
    output logic [ADDR_W-1:0]           ram_addr,
    output logic [DATA_W-1:0]           ram_wdata,
    output logic                        ram_we,
    input  logic [DATA_W-1:0]           ram_rdata,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned LVL_W = $clog2(FIFO_DEPTH) + 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_STEAL = 2'd3
    } state_e;

    state_e state_q, state_d;

    logic [ADDR_W-1:0] fifo_addr_q [FIFO_DEPTH];
    logic [DATA_W-1:0] fifo_data_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [PTR_W-1:0]  rd_ptr_q;
    logic [LVL_W-1:0]  level_q;
    logic [LVL_W-1:0]  level_d;
    logic              wr_ready_q;
    logic              push;
    logic              pop;
    logic              fifo_empty;
    logic              fifo_full;

    logic [ADDR_W-1:0] ram_addr_q;
    logic [DATA_W-1:0] ram_wdata_q;
    logic              rd_s2_q;
    logic              miss_s2_q;
    logic [DATA_W-1:0] vga_data_q;
    logic              vga_valid_q;
    logic              vga_miss_q;
    logic              steal_due;

    assign fifo_empty = (level_q == '0);
    assign fifo_full  = (level_q == LVL_W'(FIFO_DEPTH));
    assign push       = wr_valid && wr_ready_q;
    assign pop        = (state_d == ST_WRITE) || (state_d == ST_STEAL);
    assign level_d    = level_q + LVL_W'(push) - LVL_W'(pop);

`ifdef ARB_STARVE_GUARD_EN
    localparam int unsigned CNT_W = $clog2(STALL_MAX + 1);

    logic [CNT_W-1:0] stall_cnt_q;

    // Counts consecutive cycles in which a full FIFO blocks a writer behind VGA reads.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else if (state_d == ST_STEAL) begin
            stall_cnt_q <= '0;
        end else if (fifo_full && wr_valid && vga_rd_en) begin
            stall_cnt_q <= stall_cnt_q + CNT_W'(1);
        end else begin
            stall_cnt_q <= '0;
        end
    end

    assign steal_due = (stall_cnt_q == CNT_W'(STALL_MAX));
`else
    localparam int unsigned unused_stall_max = STALL_MAX;

    assign steal_due = 1'b0;
`endif

    // State register: holds the RAM command issued at the last edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Command selection: VGA first, a stolen slot if the guard fires, else drain the FIFO.
    always_comb begin
        state_d = ST_IDLE;
        if (vga_rd_en) begin
            state_d = steal_due ? ST_STEAL : ST_READ;
        end else if (!fifo_empty) begin
            state_d = ST_WRITE;
        end
    end

    // Write FIFO storage; no reset needed since occupancy is tracked separately.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr_q[wr_ptr_q] <= wr_addr;
            fifo_data_q[wr_ptr_q] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            wr_ready_q <= 1'b1;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            level_q    <= level_d;
            wr_ready_q <= (level_d != LVL_W'(FIFO_DEPTH));
        end
    end

    // RAM command registers; address and data hold when no command is issued.
    always_ff @(posedge clk) begin
        if (rst) begin
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
        end else begin
            case (state_d)
                ST_READ: begin
                    ram_addr_q <= vga_addr;
                end
                ST_WRITE, ST_STEAL: begin
                    ram_addr_q  <= fifo_addr_q[rd_ptr_q];
                    ram_wdata_q <= fifo_data_q[rd_ptr_q];
                end
                default: begin
                end
            endcase
        end
    end

    // Read return pipeline: RAM data arrives one cycle after the address, registered the next.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_s2_q     <= 1'b0;
            miss_s2_q   <= 1'b0;
            vga_data_q  <= '0;
            vga_valid_q <= 1'b0;
            vga_miss_q  <= 1'b0;
        end else begin
            rd_s2_q     <= (state_q == ST_READ) || (state_q == ST_STEAL);
            miss_s2_q   <= (state_q == ST_STEAL);
            vga_valid_q <= rd_s2_q;
            vga_miss_q  <= miss_s2_q;
            if (rd_s2_q && !miss_s2_q) begin
                vga_data_q <= ram_rdata;
            end
        end
    end

    assign ram_addr       = ram_addr_q;
    assign ram_wdata      = ram_wdata_q;
    assign ram_we         = (state_q == ST_WRITE) || (state_q == ST_STEAL);
    assign wr_ready       = wr_ready_q;
    assign fifo_level     = level_q;
    assign vga_data       = vga_data_q;
    assign vga_data_valid = vga_valid_q;
    assign vga_miss       = vga_miss_q;

endmodule

// File: tb/tb_frame_ram_arbiter.sv
// Self-checking bench for frame_ram_arbiter: directed vector table, hand sequences,
// and randomized traffic against a queue-based reference model.
`timescale 1ns/1ps
module tb_frame_ram_arbiter;

    localparam int unsigned AW    = 16;
    localparam int unsigned DW    = 8;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned SMAX  = 4;
    localparam int unsigned NV    = 12;

    logic          clk = 1'b0;
    logic          rst;
    logic          vga_rd_en;
    logic [AW-1:0] vga_addr;
    logic [DW-1:0] vga_data;
    logic          vga_data_valid;
    logic          vga_miss;
    logic          wr_valid;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          wr_ready;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic          ram_we;
    logic [DW-1:0] ram_rdata;
    logic [4:0]    fifo_level;

    always #5 clk = ~clk;

    frame_ram_arbiter #(
        .ADDR_W(AW), .DATA_W(DW), .FIFO_DEPTH(DEPTH), .STALL_MAX(SMAX)
    ) dut (
        .clk(clk), .rst(rst),
        .vga_rd_en(vga_rd_en), .vga_addr(vga_addr), .vga_data(vga_data),
        .vga_data_valid(vga_data_valid), .vga_miss(vga_miss),
        .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we),
        .ram_rdata(ram_rdata), .fifo_level(fifo_level)
    );

    // Image RAM: single port, read-first, one-cycle read; preload port for the bench.
    logic [7:0]  ram_mem [65536];
    logic        pre_en = 1'b0;
    logic [15:0] pre_addr = '0;
    logic [7:0]  pre_data = '0;

    always @(posedge clk) begin
        if (ram_we) ram_mem[ram_addr] <= ram_wdata;
        if (pre_en) ram_mem[pre_addr] <= pre_data;
        ram_rdata <= ram_mem[ram_addr];
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: pending writes in acceptance order, a shadow of RAM contents
    // as seen by reads, and outstanding reads with the cycle their data is due.
    typedef struct packed {
        logic [15:0] a;
        logic [7:0]  d;
    } wr_t;

    typedef struct {
        int         due;
        logic [7:0] d;
        logic       miss;
    } rd_t;

    wr_t        m_q[$];
    rd_t        m_rd[$];
    logic [7:0] shadow [65536];
    logic [7:0] m_last = '0;
    int         cyc = 0;
    int         m_stall = 0;
    int         obs_we = 0;
    int         obs_miss = 0;

    task automatic step(input logic rd, input logic [15:0] ra, input logic wv,
                        input logic [15:0] wa, input logic [7:0] wd, output logic acc);
        logic steal;
        logic do_wr;
        int   lvl_pre;
        wr_t  h;
        rd_t  r;
        logic exp_v;
        logic exp_m;
        vga_rd_en = rd;
        vga_addr  = ra;
        wr_valid  = wv;
        wr_addr   = wa;
        wr_data   = wd;
        lvl_pre   = m_q.size();
        acc       = wv && (lvl_pre != DEPTH);
        h         = '0;
        @(posedge clk);
        cyc++;
        steal = 1'b0;
`ifdef ARB_STARVE_GUARD_EN
        steal = rd && (m_stall >= SMAX);
        if (steal) m_stall = 0;
        else if (rd && wv && lvl_pre == DEPTH) m_stall++;
        else m_stall = 0;
`endif
        do_wr = (!rd || steal) && (lvl_pre > 0);
        if (rd) m_rd.push_back('{cyc + 2, steal ? 8'h00 : shadow[ra], steal});
        if (do_wr) begin
            h = m_q.pop_front();
            shadow[h.a] = h.d;
        end
        if (acc) m_q.push_back('{wa, wd});
        #1;
        chk("ram_we", 32'(ram_we), 32'(do_wr));
        if (do_wr) begin
            chk("wr_addr_order", 32'(ram_addr), 32'(h.a));
            chk("wr_data_order", 32'(ram_wdata), 32'(h.d));
        end else if (rd) begin
            chk("rd_addr", 32'(ram_addr), 32'(ra));
        end
        chk("wr_ready", 32'(wr_ready), 32'(m_q.size() != DEPTH));
        chk("fifo_level", 32'(fifo_level), 32'(m_q.size()));
        exp_v = (m_rd.size() > 0) && (m_rd[0].due == cyc);
        exp_m = 1'b0;
        if (exp_v) begin
            r = m_rd.pop_front();
            exp_m = r.miss;
            if (!r.miss) m_last = r.d;
        end
        chk("vga_valid", 32'(vga_data_valid), 32'(exp_v));
        chk("vga_miss", 32'(vga_miss), 32'(exp_m));
        chk("vga_data", 32'(vga_data), 32'(m_last));
        obs_we   += int'(ram_we);
        obs_miss += int'(vga_miss);
    endtask

    task automatic do_reset(input int cycles);
        rst       = 1'b1;
        vga_rd_en = 1'b0;
        wr_valid  = 1'b0;
        repeat (cycles) @(posedge clk);
        #1;
        m_q.delete();
        m_rd.delete();
        m_last  = '0;
        m_stall = 0;
        shadow  = ram_mem;
        chk("rst_ram_we", 32'(ram_we), 32'd0);
        chk("rst_wr_ready", 32'(wr_ready), 32'd1);
        chk("rst_level", 32'(fifo_level), 32'd0);
        chk("rst_valid", 32'(vga_data_valid), 32'd0);
        chk("rst_miss", 32'(vga_miss), 32'd0);
        chk("rst_data", 32'(vga_data), 32'd0);
        chk("rst_ram_addr", 32'(ram_addr), 32'd0);
        rst = 1'b0;
    endtask

    typedef struct {
        logic        rd;
        logic [15:0] ra;
        logic        wv;
        logic [15:0] wa;
        logic [7:0]  wd;
        logic        we;
        logic [15:0] addr;
        logic [7:0]  wdat;
        logic        vld;
        logic [7:0]  data;
        logic [4:0]  lvl;
    } vec_t;

    function automatic vec_t mk(logic rd, logic [15:0] ra, logic wv, logic [15:0] wa,
                                logic [7:0] wd, logic we, logic [15:0] ad, logic [7:0] wdat,
                                logic vld, logic [7:0] dat, int lvl);
        vec_t v;
        v = '{rd, ra, wv, wa, wd, we, ad, wdat, vld, dat, 5'(lvl)};
        return v;
    endfunction

    initial begin
        vec_t vecs [NV];
        wr_t  pend[$];
        logic acc;
        int   accepted;
        int   exp_blk_acc;
        int   exp_blk_we;
        int   exp_rel_we;
        int   exp_st_we;

        // Read of preloaded 0x0102, three queued writes, then readback of them.
        vecs[0]  = mk(1, 16'h0102, 0, 16'h0000, 8'h00, 0, 16'h0102, 8'h00, 0, 8'h00, 0);
        vecs[1]  = mk(0, 16'h0000, 1, 16'h0010, 8'h11, 0, 16'h0102, 8'h00, 0, 8'h00, 1);
        vecs[2]  = mk(0, 16'h0000, 1, 16'h0011, 8'h22, 1, 16'h0010, 8'h11, 1, 8'h5A, 1);
        vecs[3]  = mk(0, 16'h0000, 1, 16'h0012, 8'h33, 1, 16'h0011, 8'h22, 0, 8'h5A, 1);
        vecs[4]  = mk(0, 16'h0000, 0, 16'h0000, 8'h00, 1, 16'h0012, 8'h33, 0, 8'h5A, 0);
        vecs[5]  = mk(0, 16'h0000, 0, 16'h0000, 8'h00, 0, 16'h0012, 8'h33, 0, 8'h5A, 0);
        vecs[6]  = mk(1, 16'h0010, 0, 16'h0000, 8'h00, 0, 16'h0010, 8'h33, 0, 8'h5A, 0);
        vecs[7]  = mk(1, 16'h0011, 0, 16'h0000, 8'h00, 0, 16'h0011, 8'h33, 0, 8'h5A, 0);
        vecs[8]  = mk(1, 16'h0012, 0, 16'h0000, 8'h00, 0, 16'h0012, 8'h33, 1, 8'h11, 0);
        vecs[9]  = mk(0, 16'h0000, 0, 16'h0000, 8'h00, 0, 16'h0012, 8'h33, 1, 8'h22, 0);
        vecs[10] = mk(0, 16'h0000, 0, 16'h0000, 8'h00, 0, 16'h0012, 8'h33, 1, 8'h33, 0);
        vecs[11] = mk(0, 16'h0000, 0, 16'h0000, 8'h00, 0, 16'h0012, 8'h33, 0, 8'h33, 0);

`ifdef ARB_STARVE_GUARD_EN
        exp_blk_acc = 20; exp_blk_we = 4; exp_rel_we = 16; exp_st_we = 1;
`else
        exp_blk_acc = 16; exp_blk_we = 0; exp_rel_we = 20; exp_st_we = 0;
`endif

        rst = 1'b1; vga_rd_en = 1'b0; vga_addr = '0;
        wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
        pre_en = 1'b1; pre_addr = 16'h0102; pre_data = 8'h5A;
        @(posedge clk);
        #1 pre_en = 1'b0;
        do_reset(2);

        for (int i = 0; i < int'(NV); i++) begin
            vga_rd_en = vecs[i].rd; vga_addr = vecs[i].ra;
            wr_valid = vecs[i].wv; wr_addr = vecs[i].wa; wr_data = vecs[i].wd;
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d ram_we", i), 32'(ram_we), 32'(vecs[i].we));
            chk($sformatf("vec%0d ram_addr", i), 32'(ram_addr), 32'(vecs[i].addr));
            chk($sformatf("vec%0d ram_wdata", i), 32'(ram_wdata), 32'(vecs[i].wdat));
            chk($sformatf("vec%0d valid", i), 32'(vga_data_valid), 32'(vecs[i].vld));
            chk($sformatf("vec%0d vga_data", i), 32'(vga_data), 32'(vecs[i].data));
            chk($sformatf("vec%0d level", i), 32'(fifo_level), 32'(vecs[i].lvl));
        end

        // Active line blocks writes, then release drains the FIFO.
        do_reset(1);
        for (int i = 0; i < 20; i++) pend.push_back('{16'(16'h0200 + i), 8'($urandom)});
        accepted = 0; obs_we = 0;
        for (int c = 0; c < 100; c++) begin
            if (pend.size() > 0) step(1'b1, 16'($urandom_range(0, 255)), 1'b1, pend[0].a, pend[0].d, acc);
            else step(1'b1, 16'($urandom_range(0, 255)), 1'b0, 16'h0, 8'h0, acc);
            if (acc) begin void'(pend.pop_front()); accepted++; end
        end
        chk("block_accepted", 32'(accepted), 32'(exp_blk_acc));
        chk("block_ram_we", 32'(obs_we), 32'(exp_blk_we));
        chk("block_level", 32'(fifo_level), 32'd16);
        obs_we = 0;
        for (int c = 0; c < 40; c++) begin
            if (pend.size() > 0) step(1'b0, 16'h0, 1'b1, pend[0].a, pend[0].d, acc);
            else step(1'b0, 16'h0, 1'b0, 16'h0, 8'h0, acc);
            if (acc) begin void'(pend.pop_front()); accepted++; end
        end
        chk("release_ram_we", 32'(obs_we), 32'(exp_rel_we));
        chk("release_accepted", 32'(accepted), 32'd20);

        // Reset with queued writes discards them.
        for (int c = 0; c < 8; c++) step(1'b1, 16'h0300, 1'b1, 16'(16'h0400 + c), 8'hEE, acc);
        chk("pre_reset_level", 32'(fifo_level), 32'd8);
        do_reset(1);
        obs_we = 0;
        for (int c = 0; c < 20; c++) step(1'b0, 16'h0, 1'b0, 16'h0, 8'h0, acc);
        chk("post_reset_no_we", 32'(obs_we), 32'd0);

        // Full FIFO with a blocked writer behind a continuous read stream.
        for (int c = 0; c < 16; c++) step(1'b1, 16'($urandom_range(0, 63)), 1'b1, 16'(16'h0500 + c), 8'($urandom), acc);
        obs_we = 0; obs_miss = 0;
        for (int c = 0; c < 8; c++) step(1'b1, 16'($urandom_range(0, 63)), 1'b1, 16'h0600, 8'hA5, acc);
        chk("starve_ram_we", 32'(obs_we), 32'(exp_st_we));
        chk("starve_miss", 32'(obs_miss), 32'(exp_st_we));

        // Random line/blanking traffic over a small address window to hit hazards.
        for (int c = 0; c < 3000; c++) begin
            logic rd;
            if ((c % 48) < 32) rd = ($urandom_range(0, 7) != 0);
            else rd = ($urandom_range(0, 7) == 0);
            step(rd, 16'($urandom_range(0, 63)), 1'($urandom_range(0, 1)),
                 16'($urandom_range(0, 63)), 8'($urandom), acc);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
